// File: rtl/cpu_pkg.sv
// Shared CPU constants, register-file FSM state type and read-port slicing helper.
package cpu_pkg;

  localparam int unsigned CPU_DATA_W = 8;
  localparam int unsigned CPU_ADDR_W = 3;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // LSB of port k's field inside a flat bus of w-bit fields.
  function automatic int unsigned port_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/reg_file_rdport.sv
// One combinational read port: storage mux, hardwired-zero check, write bypass and READY mask.
module reg_file_rdport #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter bit          BYPASS   = 1'b0,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic [DATA_W-1:0] i_regs [2**ADDR_W],
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_ready,
  input  logic              i_wr_commit,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_data
);

  logic w_bypass_hit;
  logic w_zero_hit;

  assign w_bypass_hit = BYPASS && i_wr_commit && (i_wr_addr == i_addr);
  assign w_zero_hit   = ZERO_REG && (i_addr == '0);

  // Applied lowest priority first so later assignments win.
  always_comb begin
    o_data = i_regs[i_addr];
    if (w_bypass_hit) o_data = i_wr_data;
    if (w_zero_hit)   o_data = '0;
    if (!i_ready)     o_data = '0;
  end

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file with post-reset clear sequence, optional bypass and zero register.
module reg_file_param
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = CPU_DATA_W,
  parameter int unsigned ADDR_W   = CPU_ADDR_W,
  parameter int unsigned NRD      = 2,
  parameter bit          BYPASS   = 1'b0,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  WRITE,
  input  logic                  BUSYWAIT,
  input  logic [ADDR_W-1:0]     INADDRESS,
  input  logic [DATA_W-1:0]     IN,
  input  logic [NRD*ADDR_W-1:0] OUTADDRESS,
  output logic [NRD*DATA_W-1:0] OUT,
  output logic                  READY
);

  localparam int unsigned       NREGS    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  logic [DATA_W-1:0] r_regs [NREGS];
  state_e            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_ready;

  logic w_clr_en;
  logic w_zero_hit;
  logic w_commit;

  assign w_clr_en   = !RESET && (r_state == ST_INIT);
  assign w_zero_hit = ZERO_REG && (INADDRESS == '0);
  // RESET blocks the commit so a write coinciding with reset is lost and never bypassed.
  assign w_commit   = !RESET && (r_state == ST_RUN) && WRITE && !BUSYWAIT && !w_zero_hit;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else if (r_state == ST_INIT) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LAST_IDX) begin
        r_state <= ST_RUN;
        r_ready <= 1'b1;
      end
    end
  end

  // Storage has no reset; it is cleared by the INIT walk instead.
  always_ff @(posedge CLK) begin
    if (w_clr_en) begin
      r_regs[r_cnt] <= '0;
    end else if (w_commit) begin
      r_regs[INADDRESS] <= IN;
    end
  end

  assign READY = r_ready;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    reg_file_rdport #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .BYPASS  (BYPASS),
      .ZERO_REG(ZERO_REG)
    ) u_rdport (
      .i_regs     (r_regs),
      .i_addr     (OUTADDRESS[port_lsb(k, ADDR_W) +: ADDR_W]),
      .i_ready    (r_ready),
      .i_wr_commit(w_commit),
      .i_wr_addr  (INADDRESS),
      .i_wr_data  (IN),
      .o_data     (OUT[port_lsb(k, DATA_W) +: DATA_W])
    );
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench: default, bypass+zero-reg, and 16x16x3 configurations driven side by side.
module tb_reg_file_param;

  logic        clk;
  // Shared stimulus for the two 8x8 instances.
  logic        rst_ab, wr, busy;
  logic [2:0]  inaddr;
  logic [7:0]  din;
  logic [5:0]  raddr;
  logic [15:0] a_out, b_out;
  logic        a_ready, b_ready;
  // 16-bit, 16-register, 3-port instance.
  logic        rst_c, c_wr, c_busy;
  logic [3:0]  c_inaddr;
  logic [15:0] c_din;
  logic [11:0] c_raddr;
  logic [47:0] c_out;
  logic        c_ready;

  int n_total = 0;
  int n_bad   = 0;

  reg_file_param u_dut_a (
    .CLK(clk), .RESET(rst_ab), .WRITE(wr), .BUSYWAIT(busy), .INADDRESS(inaddr), .IN(din),
    .OUTADDRESS(raddr), .OUT(a_out), .READY(a_ready)
  );

  reg_file_param #(.BYPASS(1'b1), .ZERO_REG(1'b1)) u_dut_b (
    .CLK(clk), .RESET(rst_ab), .WRITE(wr), .BUSYWAIT(busy), .INADDRESS(inaddr), .IN(din),
    .OUTADDRESS(raddr), .OUT(b_out), .READY(b_ready)
  );

  reg_file_param #(.DATA_W(16), .ADDR_W(4), .NRD(3)) u_dut_c (
    .CLK(clk), .RESET(rst_c), .WRITE(c_wr), .BUSYWAIT(c_busy), .INADDRESS(c_inaddr),
    .IN(c_din), .OUTADDRESS(c_raddr), .OUT(c_out), .READY(c_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_ab = 1'b1; wr = 1'b0; busy = 1'b0; inaddr = '0; din = '0; raddr = '0;
    rst_c = 1'b1; c_wr = 1'b0; c_busy = 1'b0; c_inaddr = '0; c_din = '0; c_raddr = '0;

    // Clear sequence: reset on edge 0 only, a write to r3 held through INIT.
    step();
    check("rst_ready_a", 32'(a_ready), 0);
    check("rst_out_a", 32'(a_out), 0);
    check("rst_ready_b", 32'(b_ready), 0);
    rst_ab = 1'b0; wr = 1'b1; inaddr = 3'd3; din = 8'hAA; raddr = {3'd3, 3'd3};
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("init_ready_a_e%0d", i), 32'(a_ready), (i == 8) ? 1 : 0);
      check($sformatf("init_ready_b_e%0d", i), 32'(b_ready), (i == 8) ? 1 : 0);
      if (i < 8) check($sformatf("init_out_a_e%0d", i), 32'(a_out), 0);
    end
    wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      raddr = {3'(7 - i), 3'(i)};
      #1;
      check($sformatf("clr_a_r%0d", i), 32'(a_out), 0);
      check($sformatf("clr_b_r%0d", i), 32'(b_out), 0);
    end

    // Basic write/read.
    wr = 1'b1; inaddr = 3'd5; din = 8'h3C;
    step();
    inaddr = 3'd2; din = 8'hF0;
    step();
    wr = 1'b0; raddr = {3'd2, 3'd5};
    #1;
    check("rw_a", 32'(a_out), 32'hF03C);
    check("rw_b", 32'(b_out), 32'hF03C);

    // Stall: write held off by BUSYWAIT, then re-presented.
    wr = 1'b1; inaddr = 3'd1; din = 8'h55; busy = 1'b1; raddr = {3'd1, 3'd1};
    #1;
    check("stall_byp_b", 32'(b_out), 0);
    step();
    check("stall_a", 32'(a_out), 0);
    busy = 1'b0;
    #1;
    check("stall_rel_byp_b", 32'(b_out), 32'h5555);
    check("stall_rel_pre_a", 32'(a_out), 0);
    step();
    wr = 1'b0;
    #1;
    check("stall_post_a", 32'(a_out), 32'h5555);

    // Bypass: both ports on r4 while r4 is being written.
    wr = 1'b1; inaddr = 3'd4; din = 8'h99; raddr = {3'd4, 3'd4};
    #1;
    check("byp_pre_b", 32'(b_out), 32'h9999);
    check("byp_pre_a", 32'(a_out), 0);
    step();
    wr = 1'b0;
    #1;
    check("byp_post_a", 32'(a_out), 32'h9999);
    check("byp_post_b", 32'(b_out), 32'h9999);

    // Zero register.
    wr = 1'b1; inaddr = 3'd0; din = 8'hFF; raddr = {3'd0, 3'd0};
    #1;
    check("zero_pre_b", 32'(b_out), 0);
    step();
    wr = 1'b0;
    #1;
    check("zero_post_b", 32'(b_out), 0);
    check("zero_post_a", 32'(a_out), 32'hFFFF);

    // Reset in RUN beats a concurrent write, including the bypass path.
    rst_ab = 1'b1; wr = 1'b1; inaddr = 3'd6; din = 8'h77; raddr = {3'd6, 3'd6};
    #1;
    check("rstwr_byp_b", 32'(b_out), 0);
    step();
    check("rstwr_ready_a", 32'(a_ready), 0);
    check("rstwr_out_a", 32'(a_out), 0);
    rst_ab = 1'b0; wr = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("rstwr_ready2_a", 32'(a_ready), 1);
    check("rstwr_r6_a", 32'(a_out), 0);

    // Scaled instance: reset re-asserted after 5 INIT edges.
    rst_c = 1'b0;
    for (int i = 1; i <= 5; i++) step();
    check("c_mid_ready", 32'(c_ready), 0);
    rst_c = 1'b1;
    step();
    check("c_rst2_ready", 32'(c_ready), 0);
    rst_c = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      check($sformatf("c_ready_e%0d", i), 32'(c_ready), (i == 16) ? 1 : 0);
    end
    c_raddr = {4'd15, 4'd15, 4'd15};
    #1;
    check("c_r15_clr", c_out[31:0], 0);
    c_wr = 1'b1; c_inaddr = 4'd15; c_din = 16'hBEEF;
    step();
    c_wr = 1'b0;
    #1;
    check("c_p0", 32'(c_out[15:0]), 32'hBEEF);
    check("c_p1", 32'(c_out[31:16]), 32'hBEEF);
    check("c_p2", 32'(c_out[47:32]), 32'hBEEF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised successor to the CPU's 8x8 register file. It is generalised in data width, register count and read-port count, and adds:

- a sequential post-reset clear sequence with a READY flag;
- optional write-to-read bypass;
- optional hardwired zero register.

It sits between the instruction decoder/ALU and the data-memory write-back path, and honours the memory subsystem's BUSYWAIT stall.

## Interface
Parameters:
- DATA_W, 8, register width in bits
- ADDR_W, 3, address width; NREGS = 2**ADDR_W registers
- NRD, 2, number of independent read ports (1..4)
- BYPASS, 0, 1 = a same-cycle committed write is forwarded to matching read ports
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes

Ports:
- CLK  in  1  single clock, all state updates on rising edge
- RESET  in  1  synchronous, active-high; sampled on rising CLK
- WRITE  in  1  write enable
- BUSYWAIT  in  1  memory stall; when high, no write commits
- INADDRESS  in  ADDR_W  write address
- IN  in  DATA_W  write data
- OUTADDRESS  in  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- OUT  out  NRD*DATA_W  read data; port k on bits [k*DATA_W +: DATA_W]
- READY  out  1  high once the clear sequence has completed

## Operation
- FSM states: INIT, RUN.
- RESET high at a rising edge:
  - state <= INIT, clear counter <= 0, READY <= 0.
  - Storage is not touched on that edge.
- INIT:
  - Each rising edge writes 0 to regset[counter] and increments counter.
  - On the edge that clears entry NREGS-1: state <= RUN, READY <= 1.
  - The sequence takes NREGS cycles after RESET deasserts.
- RUN: a write commits at a rising edge iff WRITE=1 and BUSYWAIT=0 (and not (ZERO_REG=1 and INADDRESS=0)); then regset[INADDRESS] <= IN.
- WRITE during INIT: ignored, never queued.
- WRITE during BUSYWAIT: dropped. The CPU re-presents it after the stall.
- Reads are combinational: OUT[k] = regset[OUTADDRESS[k]].
- Read overrides, highest priority first:
  - READY=0: OUT forced to all zeros.
  - ZERO_REG=1 and address 0: OUT = 0.
  - BYPASS=1 and a write is committing this cycle with INADDRESS equal to the port address: OUT = IN.
- Multiple read ports may address the same register; all return the same value.
- Reset outputs: READY=0 and OUT=0 from the first edge with RESET high until INIT completes.

## Timing
- Write latency: data is visible on non-bypassed reads immediately after the committing edge.
- With BYPASS=1, data is visible combinationally in the same cycle.
- READY rises NREGS edges after the last edge with RESET=1.
  - Example: with RESET high for edge 0 only and default parameters, READY is 1 after edge 8.
- RESET asserted mid-INIT: counter restarts at 0. The clear sequence runs in full again.
- RESET asserted in RUN concurrent with WRITE: reset wins; the write is lost.
- Counter wrap: counter is ADDR_W bits wide. The INIT→RUN transition is decoded on counter == NREGS-1, so there is no wrap.
- BUSYWAIT has no effect on INIT progress.
- No #delays in synthesisable RTL. Simulation delays belong to the bench.

## Structure
- Shared package (cpu_pkg):
  - default DATA_W and ADDR_W constants;
  - the FSM state enum (ST_INIT, ST_RUN);
  - the read-port slice helper function.
- One natural sub-module: reg_file_rdport. It handles a single read port, including the mux, zero-reg check, bypass compare and READY mask. It is instantiated NRD times by a generate loop.
- The top level holds the storage array, the FSM/counter and the write-commit logic.

## Test plan
- Clear sequence: RESET for 1 cycle with defaults → READY low for edges 1–7 and high after edge 8. All registers read 0x00. WRITE r3=0xAA during INIT → r3 still reads 0x00.
- Basic write/read: in RUN, write r5=0x3C then r2=0xF0 → OUT port0(r5)=0x3C and OUT port1(r2)=0xF0 on the following cycle.
- Stall: WRITE r1=0x55 with BUSYWAIT=1 → r1 unchanged. Repeat the write with BUSYWAIT=0 → r1=0x55 after the edge.
- Bypass: BYPASS=1, write r4=0x99 with both ports addressing r4 → both ports show 0x99 before the edge. With BYPASS=0, both show the old value until after the edge.
- Zero register: ZERO_REG=1, write r0=0xFF → r0 reads 0x00. Repeat with ZERO_REG=0 → r0 reads 0xFF.
- Reset mid-INIT and scaling: DATA_W=16, ADDR_W=4, NRD=3; re-assert RESET at INIT cycle 5 → READY rises exactly 16 edges after the second RESET. Write 0xBEEF to r15 → all 3 ports read 0xBEEF.
